// File: rtl/ge_pkg.sv
// Shared types, constants and helpers for the GE game master and its LFSR.
package ge_pkg;

   localparam int GE_SCORE_W = 7;
   localparam int GE_LUCK_W  = 2;
   localparam int GE_BONUS_W = 2;

   localparam logic [GE_SCORE_W-1:0] GE_MAX_SCORE = 7'd100;
   localparam logic [15:0]           GE_LFSR_TAPS = 16'hB400;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROLL,
      ST_ASK,
      ST_EVAL,
      ST_DONE
   } ge_state_e;

   // Galois right-shift step; shared by the LFSR and the roll look-ahead.
   function automatic logic [15:0] ge_lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? GE_LFSR_TAPS : 16'h0000);
   endfunction

   // Folds 101..127 back into 74..100 so difficulty stays in 0..100.
   function automatic logic [GE_SCORE_W-1:0] ge_hard_map(input logic [GE_SCORE_W-1:0] r);
      return (r > GE_MAX_SCORE) ? r - 7'd27 : r;
   endfunction

   function automatic logic [GE_SCORE_W-1:0] ge_clamp(input logic [GE_SCORE_W-1:0] v);
      return (v > GE_MAX_SCORE) ? GE_MAX_SCORE : v;
   endfunction

endpackage

// File: rtl/ge_game_ctrl_if.sv
// Effort handshake plus the stage-evaluator bus. The game master is the master.
interface ge_game_ctrl_if;
   import ge_pkg::*;

   logic                  effort_valid;
   logic [GE_SCORE_W-1:0] effort;
   logic                  effort_ready;
   logic [GE_SCORE_W-1:0] hard;
   logic [GE_LUCK_W-1:0]  luck;
   logic [GE_SCORE_W-1:0] eff_out;
   logic                  pass_prev;
   logic [GE_BONUS_W-1:0] bonus_prev;
   logic                  stage_pass;
   logic [GE_BONUS_W-1:0] stage_bonus;

   modport master (
      input  effort_valid, effort, stage_pass, stage_bonus,
      output effort_ready, hard, luck, eff_out, pass_prev, bonus_prev
   );

   modport slave (
      output effort_valid, effort, stage_pass, stage_bonus,
      input  effort_ready, hard, luck, eff_out, pass_prev, bonus_prev
   );

endinterface

// File: rtl/ge_lfsr16.sv
// 16-bit Galois LFSR that advances only when stepped; reset reloads the seed.
module ge_lfsr16
   import ge_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   output logic [15:0] q
);

   logic [15:0] q_q, q_d;

   // Next state: hold unless stepped.
   always_comb begin
      q_d = q_q;
      if (step) q_d = ge_lfsr_next(q_q);
   end

   // State register with synchronous reseed.
   always_ff @(posedge clk) begin
      if (rst) q_q <= SEED;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/ge_game_ctrl.sv
// Game master: rolls per-stage difficulty/luck, collects effort, samples the
// stage evaluator and carries pass/bonus through the stage chain.
//
// state | meaning
// IDLE  | waiting for start
// ROLL  | step LFSR, register hard/luck for this stage
// ASK   | effort_ready high, waiting for effort_valid
// EVAL  | evaluator inputs stable, sample pass/bonus at closing edge
// DONE  | one-cycle done pulse, result held
module ge_game_ctrl
   import ge_pkg::*;
#(
   parameter int          NUM_STAGES = 4,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   ge_game_ctrl_if.master        bus,
   output logic [2:0]            stage_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  win,
   output logic [GE_BONUS_W-1:0] final_bonus
);

   localparam logic [2:0] LAST_IDX = 3'(NUM_STAGES - 1);

   ge_state_e             state_q, state_d;
   logic [GE_SCORE_W-1:0] hard_q, hard_d, eff_q, eff_d;
   logic [GE_LUCK_W-1:0]  luck_q, luck_d;
   logic                  pass_prev_q, pass_prev_d;
   logic [GE_BONUS_W-1:0] bonus_prev_q, bonus_prev_d;
   logic [2:0]            stage_idx_q, stage_idx_d;
   logic                  win_q, win_d;
   logic [GE_BONUS_W-1:0] final_bonus_q, final_bonus_d;
   logic                  ready_q, ready_d, busy_q, busy_d, done_q, done_d;
   logic [15:0]           lfsr_q, lfsr_n;
   logic                  lfsr_unused;

   ge_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .step (state_q == ST_ROLL),
      .q    (lfsr_q)
   );

   // The roll uses the value the LFSR takes at the end of ROLL.
   assign lfsr_n      = ge_lfsr_next(lfsr_q);
   assign lfsr_unused = ^lfsr_n[15:9];

   // Next-state and datapath decisions.
   always_comb begin
      state_d       = state_q;
      hard_d        = hard_q;
      luck_d        = luck_q;
      eff_d         = eff_q;
      pass_prev_d   = pass_prev_q;
      bonus_prev_d  = bonus_prev_q;
      stage_idx_d   = stage_idx_q;
      win_d         = win_q;
      final_bonus_d = final_bonus_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               stage_idx_d   = 3'd0;
               pass_prev_d   = 1'b1;
               bonus_prev_d  = '0;
               win_d         = 1'b0;
               final_bonus_d = '0;
               state_d       = ST_ROLL;
            end
         end
         ST_ROLL: begin
            hard_d  = ge_hard_map(lfsr_n[6:0]);
            luck_d  = lfsr_n[8:7];
            state_d = ST_ASK;
         end
         ST_ASK: begin
            if (bus.effort_valid) begin
               eff_d   = ge_clamp(bus.effort);
               state_d = ST_EVAL;
            end
         end
         ST_EVAL: begin
            if (!bus.stage_pass) begin
               win_d         = 1'b0;
               final_bonus_d = '0;
               state_d       = ST_DONE;
            end else if (stage_idx_q == LAST_IDX) begin
               win_d         = 1'b1;
               final_bonus_d = bus.stage_bonus;
               state_d       = ST_DONE;
            end else begin
               bonus_prev_d = bus.stage_bonus;
               stage_idx_d  = stage_idx_q + 3'd1;
               state_d      = ST_ROLL;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_ASK);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   // Single state/output register bank with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         hard_q        <= '0;
         luck_q        <= '0;
         eff_q         <= '0;
         pass_prev_q   <= 1'b0;
         bonus_prev_q  <= '0;
         stage_idx_q   <= 3'd0;
         win_q         <= 1'b0;
         final_bonus_q <= '0;
         ready_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         hard_q        <= hard_d;
         luck_q        <= luck_d;
         eff_q         <= eff_d;
         pass_prev_q   <= pass_prev_d;
         bonus_prev_q  <= bonus_prev_d;
         stage_idx_q   <= stage_idx_d;
         win_q         <= win_d;
         final_bonus_q <= final_bonus_d;
         ready_q       <= ready_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign bus.effort_ready = ready_q;
   assign bus.hard         = hard_q;
   assign bus.luck         = luck_q;
   assign bus.eff_out      = eff_q;
   assign bus.pass_prev    = pass_prev_q;
   assign bus.bonus_prev   = bonus_prev_q;
   assign stage_idx        = stage_idx_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign win              = win_q;
   assign final_bonus      = final_bonus_q;

endmodule
